// File: rtl/sv_uart_tx_fifo.sv
// rtl/sv_uart_tx_fifo.sv - UART transmitter fed by a word FIFO, with break generation.
// Frame settings are captured when a word leaves the FIFO and stay fixed for that frame.
module sv_uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [15:0]                   idivider,
  input  logic [1:0]                    iparity,
  input  logic                          istop2,
  input  logic                          ibreak,
  output logic                          otx,
  output logic                          obusy,
  output logic [$clog2(FIFO_DEPTH):0]   olevel
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  push, pop, fifo_empty;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           per_q, per_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  otx_q, otx_d;
  logic                  start_frame, baud_end;
  logic [15:0]           per_cur;
  logic [DATA_WIDTH-1:0] head;

  assign s_axis_tready = level_q < LW'(FIFO_DEPTH);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign fifo_empty    = level_q == '0;
  assign head          = mem_q[rd_ptr_q];
  assign per_cur       = (idivider < 16'd2) ? 16'd1 : idivider;
  assign baud_end      = cnt_q == per_q - 16'd1;
  assign olevel        = level_q;
  assign obusy         = state_q != S_IDLE;
  assign otx           = otx_q;

  always_ff @(posedge iclk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    data_d      = data_q;
    per_d       = per_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    pop         = 1'b0;
    start_frame = 1'b0;
    otx_d       = 1'b1;
    // otx is driven from the current state, so the line lags the FSM by one cycle.
    case (state_q)
      S_IDLE: begin
        if (ibreak)           state_d = S_BREAK;
        else if (!fifo_empty) start_frame = 1'b1;
      end
      S_START: begin
        otx_d = 1'b0;
        if (baud_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_DATA: begin
        otx_d = data_q[0];
        if (baud_end) begin
          cnt_d  = '0;
          data_d = data_q >> 1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else bit_d = bit_q + 1'b1;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_PARITY: begin
        otx_d = par_bit_q;
        if (baud_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_STOP: begin
        if (baud_end) begin
          cnt_d = '0;
          if (bit_q == BW'(stop2_q)) begin
            bit_d = '0;
            if (!fifo_empty && !ibreak) start_frame = 1'b1;
            else                        state_d = S_IDLE;
          end else bit_d = bit_q + 1'b1;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_BREAK: begin
        otx_d = 1'b0;
        if (!ibreak) begin
          state_d = S_MARK;
          cnt_d   = '0;
        end
      end
      S_MARK: begin
        if (cnt_q >= per_cur - 16'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
    if (start_frame) begin
      state_d   = S_START;
      pop       = 1'b1;
      cnt_d     = '0;
      bit_d     = '0;
      data_d    = head;
      per_d     = per_cur;
      par_en_d  = (iparity == 2'd1) || (iparity == 2'd2);
      par_bit_d = (^head) ^ (iparity == 2'd2);
      stop2_d   = istop2;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      per_q     <= 16'd1;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      otx_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      per_q     <= per_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      otx_q     <= otx_d;
    end
  end

endmodule

// File: tb/tb_sv_uart_tx_fifo.sv
// tb/tb_sv_uart_tx_fifo.sv - self-checking bench for sv_uart_tx_fifo.
// A line monitor decodes every frame against the queue of accepted words and their settings.
module tb_sv_uart_tx_fifo;
  logic        iclk = 1'b0;
  logic        irst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] idivider;
  logic [1:0]  iparity;
  logic        istop2;
  logic        ibreak;
  logic        otx;
  logic        obusy;
  logic [2:0]  olevel;

  sv_uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .iclk(iclk), .irst(irst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .idivider(idivider), .iparity(iparity), .istop2(istop2), .ibreak(ibreak),
    .otx(otx), .obusy(obusy), .olevel(olevel)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [7:0] w;
    int         per;
    int         par;
    int         s2;
  } frame_t;

  frame_t exp_q[$];
  int     start_q[$];
  int     end_q[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     frames_rx = 0;
  int     cfg_div, cfg_par, cfg_s2;
  int     a, t, r, nf, k, n, n_acc;
  logic   acc;

  always @(posedge iclk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
  endtask

  function automatic int per_of(input int d);
    return (d < 2) ? 1 : d;
  endfunction

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic set_cfg(input int d, input int p, input int s);
    cfg_div = d; cfg_par = p; cfg_s2 = s;
    idivider = 16'(d); iparity = 2'(p); istop2 = s[0];
  endtask

  task automatic push_word(input logic [7:0] w, output int acc_cyc);
    int kk;
    kk = 0;
    while (!s_axis_tready && kk < 20000) begin tick(); kk++; end
    check("push_ready", int'(s_axis_tready), 1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = w;
    tick();
    s_axis_tvalid = 1'b0;
    acc_cyc = cyc;
    exp_q.push_back('{w, per_of(cfg_div), cfg_par, cfg_s2});
  endtask

  task automatic wait_frames(input int target);
    int kk;
    kk = 0;
    while (frames_rx < target && kk < 20000) begin tick(); kk++; end
    check("frames_done", frames_rx, target);
  endtask

  // Line monitor: frame layout is rebuilt from the accepted word and its settings.
  logic        m_prev = 1'b1;
  logic        m_in = 1'b0;
  logic [11:0] m_bits;
  int          m_nb, m_per, m_idx;
  frame_t      m_f;

  initial begin
    forever begin
      @(negedge iclk);
      if (irst) m_in = 1'b0;
      else begin
        if (!m_in && m_prev && !otx && !ibreak) begin
          check("frame_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            m_f = exp_q.pop_front();
            m_bits = '0;
            for (int i = 0; i < 8; i++) m_bits[1+i] = m_f.w[i];
            m_nb = 9;
            if (m_f.par == 1 || m_f.par == 2) begin
              m_bits[m_nb] = (^m_f.w) ^ (m_f.par == 2);
              m_nb++;
            end
            m_bits[m_nb] = 1'b1;
            m_nb++;
            if (m_f.s2 != 0) begin m_bits[m_nb] = 1'b1; m_nb++; end
            m_per = m_f.per;
            m_idx = 0;
            m_in  = 1'b1;
            start_q.push_back(cyc);
          end
        end
        if (m_in) begin
          check("frame_bit", int'(otx), int'(m_bits[m_idx / m_per]));
          m_idx++;
          if (m_idx == m_nb * m_per) begin
            m_in = 1'b0;
            frames_rx++;
            end_q.push_back(cyc);
          end
        end
      end
      m_prev = otx;
    end
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got 0, want 1");
    $fatal(1, "timeout");
  end

  initial begin
    irst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 8'h3C; ibreak = 1'b0;
    set_cfg(4, 0, 0);
    tick(); tick(); tick();
    check("rst_otx", int'(otx), 1);
    check("rst_busy", int'(obusy), 0);
    check("rst_level", int'(olevel), 0);
    check("rst_ready", int'(s_axis_tready), 1);
    irst = 1'b0; s_axis_tvalid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rst_nostore", int'(olevel), 0);
    check("rst_idle_otx", int'(otx), 1);

    // 0xA5, no parity, one stop; start bit 2 cycles after the accepting edge
    nf = frames_rx;
    push_word(8'hA5, a);
    check("push_level", int'(olevel), 1);
    tick();
    check("busy_started", int'(obusy), 1);
    wait_frames(nf + 1);
    check("latency", start_q[start_q.size()-1], a + 2);
    tick();
    check("idle_after", int'(otx), 1);
    check("idle_busy", int'(obusy), 0);

    // parity even then odd
    set_cfg(4, 1, 0);
    push_word(8'hA5, a);
    wait_frames(nf + 2);
    set_cfg(4, 2, 0);
    push_word(8'hA5, a);
    wait_frames(nf + 3);
    check("par_frame_len", end_q[end_q.size()-1] - start_q[start_q.size()-1] + 1, 44);

    // two stop bits, back-to-back frames with no gap
    set_cfg(4, 0, 1);
    nf = frames_rx;
    push_word(8'h00, a);
    push_word(8'hFF, t);
    wait_frames(nf + 2);
    check("b2b_gap", start_q[start_q.size()-1], end_q[end_q.size()-2] + 1);

    // FIFO fill with a stalled line
    set_cfg(100, 0, 0);
    nf = frames_rx;
    n_acc = 0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_axis_tdata = 8'($urandom);
      acc = s_axis_tready;
      tick();
      if (acc) begin
        n_acc++;
        exp_q.push_back('{s_axis_tdata, 100, 0, 0});
      end
    end
    s_axis_tvalid = 1'b0;
    check("fill_accepts", n_acc, 5);
    check("fill_level", int'(olevel), 4);
    check("fill_ready", int'(s_axis_tready), 0);
    wait_frames(nf + 5);

    // break requested during data bit 3
    set_cfg(4, 0, 0);
    nf = frames_rx;
    push_word(8'h5A, a);
    push_word(8'hC3, t);
    while (cyc < a + 19) tick();
    ibreak = 1'b1;
    while (cyc < a + 42) tick();
    check("brk_frame_done", frames_rx, nf + 1);
    check("brk_gap", int'(otx), 1);
    check("brk_busy", int'(obusy), 1);
    for (int i = 0; i < 18; i++) begin
      tick();
      check("brk_low", int'(otx), 0);
    end
    ibreak = 1'b0;
    r = cyc;
    tick();
    check("brk_release", int'(otx), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mark_high", int'(otx), 1);
    end
    wait_frames(nf + 2);
    check("brk_next_start", start_q[start_q.size()-1], r + 7);

    // reset mid-frame with three words queued
    set_cfg(4, 0, 0);
    nf = frames_rx;
    push_word(8'h11, a);
    push_word(8'h22, t);
    push_word(8'h33, t);
    push_word(8'h44, t);
    check("queued_level", int'(olevel), 3);
    while (cyc < a + 15) tick();
    irst = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 8'h99;
    tick();
    check("mrst_otx", int'(otx), 1);
    check("mrst_level", int'(olevel), 0);
    check("mrst_ready", int'(s_axis_tready), 1);
    check("mrst_busy", int'(obusy), 0);
    exp_q.delete();
    irst = 1'b0; s_axis_tvalid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("mrst_quiet", int'(otx), 1);
    end
    check("mrst_noframes", frames_rx, nf);

    // randomized bursts; settings are scrambled while the last frame is on the line
    for (int b = 0; b < 12; b++) begin
      set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      n  = int'($urandom_range(1, 6));
      nf = frames_rx;
      for (int i = 0; i < n; i++) push_word(8'($urandom), t);
      k = 0;
      while (olevel != 0 && k < 20000) begin tick(); k++; end
      check("rnd_drain", int'(olevel), 0);
      idivider = 16'($urandom);
      iparity  = 2'($urandom);
      istop2   = 1'($urandom);
      wait_frames(nf + n);
      k = 0;
      while (obusy && k < 100) begin tick(); k++; end
      check("rnd_idle", int'(obusy), 0);
      check("rnd_queue_empty", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sv_uart_tx_fifo.md
SV_UART_TX_FIFO -- requirements
Module: sv_uart_tx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per frame, 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16: transmit FIFO entries, power of 2, >=2.
REQ-003 iclk  input  1  clock; all logic on rising edge.
REQ-004 irst  input  1  reset: synchronous, active-high.
REQ-005 s_axis_tdata  input  DATA_WIDTH  word to transmit.
REQ-006 s_axis_tvalid  input  1  word valid.
REQ-007 s_axis_tready  output  1  FIFO can accept word.
REQ-008 idivider  input  16  iclk cycles per bit; values 0 and 1 both mean 1.
REQ-009 iparity  input  2  parity mode: 0 none, 1 even, 2 odd, 3 none.
REQ-010 istop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 ibreak  input  1  break request: hold line low.
REQ-012 otx  output  1  serial line, registered, idle high.
REQ-013 obusy  output  1  frame or break in progress.
REQ-014 olevel  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-015 s_axis_tready SHALL be high iff olevel < FIFO_DEPTH; it depends only on FIFO state, never on tvalid.
REQ-016 Push: tvalid && tready at an edge writes the word; olevel increments at that edge.
REQ-017 Simultaneous push and pop SHALL leave olevel unchanged; a pop on a full FIFO SHALL NOT admit a word in the same cycle.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK, MARK.
REQ-019 IDLE: otx=1 and obusy=0 when FIFO is empty and ibreak=0.
REQ-020 IDLE -> BREAK when ibreak=1; this takes priority over a non-empty FIFO.
REQ-021 IDLE -> START when FIFO is non-empty and ibreak=0. At this transition: pop the head word; latch idivider, iparity and istop2 for the whole frame.
REQ-022 Each of START, DATA bits, PARITY and STOP bits SHALL last exactly max(idivider,1) iclk cycles.
REQ-023 Baud counter: cleared on entry to START; wraps at period-1.
REQ-024 START drives otx=0.
REQ-025 DATA sends DATA_WIDTH bits, LSB first.
REQ-026 PARITY is entered only if the latched mode is 1 or 2.
REQ-027 Parity bit = XOR of the data bits (even mode), inverted for odd mode.
REQ-028 STOP drives otx=1 for 1 or 2 bit periods per latched istop2.
REQ-029 After the final stop bit: START directly if the FIFO is non-empty and ibreak=0, with no idle gap; otherwise IDLE.
REQ-030 Latency: with FIFO empty and FSM in IDLE, otx SHALL fall exactly 2 iclk after the accepting edge.
REQ-031 ibreak asserted mid-frame SHALL NOT affect the current frame; the break is taken at the frame boundary.
REQ-032 BREAK: otx=0 while ibreak=1.
REQ-033 On ibreak release: MARK, otx=1 for one bit period (current idivider), then IDLE.
REQ-034 obusy=1 in every state except IDLE.
REQ-035 Changes on idivider, iparity or istop2 mid-frame SHALL NOT alter the frame in progress.

Reset
REQ-036 irst SHALL take effect at the next edge regardless of state, including mid-frame.
REQ-037 Reset values: FSM=IDLE, FIFO empty, olevel=0, s_axis_tready=1, otx=1, obusy=0, baud and bit counters 0.
REQ-038 A word presented with tvalid during reset SHALL NOT be stored.

Verification
REQ-039 DATA_WIDTH=8, idivider=4, iparity=0, istop2=0, push 0xA5 -> otx 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; falling edge 2 cycles after the accept edge.
REQ-040 Same word, iparity=1 -> parity bit 0 before stop; iparity=2 -> parity bit 1; frame 11 bits = 44 cycles.
REQ-041 istop2=1, push 0x00 and 0xFF back-to-back -> exactly 2 stop periods (8 cycles high) between the frames, no extra gap.
REQ-042 FIFO_DEPTH=4, hold tvalid with the line stalled (idivider=100) -> tready drops after 5 accepts (1 popped + 4 stored), olevel=4, all 5 words later transmitted in order.
REQ-043 Assert ibreak during data bit 3 -> frame completes, otx low while ibreak high, then high for one bit period, then next queued frame starts.
REQ-044 irst pulse mid-data-bit with 3 words queued -> next cycle otx=1, olevel=0, tready=1, no further frames.
